id_ex_stage: RTL

Pipeline register between decode (S1) and execute (S2) of the 3-stage datapath. Captures decoded fields and register-file operands from S1, resolves operand B (register vs. sign-extended immediate), and presents `S2_ReadData1`, `mux_out` and `S2_ALUOp` directly to the ALU. Supports stall and flush, and optionally forwards the S3 result to resolve back-to-back RAW hazards without software NOPs.

---
 rtl/id_ex_if.sv | 43 ++++
 rtl/id_ex_stage.sv | 123 ++++++++++++
 2 files changed

// File: rtl/id_ex_if.sv
// Decode-to-execute stage bundle: S1 capture fields, S3 forward source, S2 ALU-facing outputs.
// The slave modport is the stage itself; the master modport is the surrounding pipeline.
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int IMM_W  = 16
);
    logic              S1_valid;
    logic [REG_AW-1:0] S1_ReadSelect1;
    logic [REG_AW-1:0] S1_ReadSelect2;
    logic [DATA_W-1:0] S1_ReadData1;
    logic [DATA_W-1:0] S1_ReadData2;
    logic [IMM_W-1:0]  S1_Imm;
    logic              S1_DataSource;
    logic [2:0]        S1_ALUOp;
    logic [REG_AW-1:0] S1_WriteSelect;
    logic              S1_WriteEnable;
    logic              stall;
    logic              flush;
    logic [REG_AW-1:0] S3_WriteSelect;
    logic              S3_WriteEnable;
    logic [DATA_W-1:0] S3_ALUOut;
    logic              S2_valid;
    logic [DATA_W-1:0] S2_ReadData1;
    logic [DATA_W-1:0] mux_out;
    logic [2:0]        S2_ALUOp;
    logic [REG_AW-1:0] S2_WriteSelect;
    logic              S2_WriteEnable;

    modport slave (
        input  S1_valid, S1_ReadSelect1, S1_ReadSelect2, S1_ReadData1, S1_ReadData2,
               S1_Imm, S1_DataSource, S1_ALUOp, S1_WriteSelect, S1_WriteEnable,
               stall, flush, S3_WriteSelect, S3_WriteEnable, S3_ALUOut,
        output S2_valid, S2_ReadData1, mux_out, S2_ALUOp, S2_WriteSelect, S2_WriteEnable
    );

    modport master (
        output S1_valid, S1_ReadSelect1, S1_ReadSelect2, S1_ReadData1, S1_ReadData2,
               S1_Imm, S1_DataSource, S1_ALUOp, S1_WriteSelect, S1_WriteEnable,
               stall, flush, S3_WriteSelect, S3_WriteEnable, S3_ALUOut,
        input  S2_valid, S2_ReadData1, mux_out, S2_ALUOp, S2_WriteSelect, S2_WriteEnable
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand-B resolution, stall and flush.
// Define ID_EX_FORWARD_EN to add distance-1 (output-side) and distance-2 (capture-side) S3 forwarding.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int IMM_W  = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    id_ex_if.slave bus
);
    localparam logic [2:0] ALUOP_BUBBLE = 3'b010;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [REG_AW-1:0] rs1_q, rs1_d;
    logic [REG_AW-1:0] rs2_q, rs2_d;
    logic              bimm_q, bimm_d;
    logic [2:0]        op_q, op_d;
    logic [REG_AW-1:0] ws_q, ws_d;
    logic              we_q, we_d;

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] a_out, b_out;
    logic [DATA_W-1:0] a_cap, b_cap;

    assign imm_ext = {{(DATA_W-IMM_W){bus.S1_Imm[IMM_W-1]}}, bus.S1_Imm};

`ifdef ID_EX_FORWARD_EN
    logic s3_live;
    logic fwd_a_out, fwd_b_out, fwd_a_cap, fwd_b_cap;

    // r0 writes never match; B taken from the immediate is never forwarded.
    assign s3_live   = bus.S3_WriteEnable && (bus.S3_WriteSelect != '0);
    assign fwd_a_out = valid_q && s3_live && (bus.S3_WriteSelect == rs1_q);
    assign fwd_b_out = valid_q && !bimm_q && s3_live && (bus.S3_WriteSelect == rs2_q);
    assign fwd_a_cap = s3_live && (bus.S3_WriteSelect == bus.S1_ReadSelect1);
    assign fwd_b_cap = s3_live && (bus.S3_WriteSelect == bus.S1_ReadSelect2);

    assign a_out = fwd_a_out ? bus.S3_ALUOut : a_q;
    assign b_out = fwd_b_out ? bus.S3_ALUOut : b_q;
    assign a_cap = fwd_a_cap ? bus.S3_ALUOut : bus.S1_ReadData1;
    assign b_cap = fwd_b_cap ? bus.S3_ALUOut : bus.S1_ReadData2;
`else
    logic unused_fwd;

    assign unused_fwd = ^{bus.S3_WriteSelect, bus.S3_WriteEnable, bus.S3_ALUOut,
                          rs1_q, rs2_q, bimm_q};
    assign a_out = a_q;
    assign b_out = b_q;
    assign a_cap = bus.S1_ReadData1;
    assign b_cap = bus.S1_ReadData2;
`endif

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        bimm_d  = bimm_q;
        op_d    = op_q;
        ws_d    = ws_q;
        we_d    = we_q;
        if (bus.flush) begin
            valid_d = 1'b0;
            a_d     = '0;
            b_d     = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            bimm_d  = 1'b0;
            op_d    = ALUOP_BUBBLE;
            ws_d    = '0;
            we_d    = 1'b0;
        end else if (bus.stall) begin
            // Reloading the presented value keeps a forwarded operand after S3 retires.
            a_d = a_out;
            b_d = b_out;
        end else begin
            valid_d = bus.S1_valid;
            a_d     = a_cap;
            b_d     = bus.S1_DataSource ? imm_ext : b_cap;
            rs1_d   = bus.S1_ReadSelect1;
            rs2_d   = bus.S1_ReadSelect2;
            bimm_d  = bus.S1_DataSource;
            op_d    = bus.S1_ALUOp;
            ws_d    = bus.S1_WriteSelect;
            we_d    = bus.S1_WriteEnable;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            bimm_q  <= 1'b0;
            op_q    <= ALUOP_BUBBLE;
            ws_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            bimm_q  <= bimm_d;
            op_q    <= op_d;
            ws_q    <= ws_d;
            we_q    <= we_d;
        end
    end

    assign bus.S2_valid       = valid_q;
    assign bus.S2_ReadData1   = a_out;
    assign bus.mux_out        = b_out;
    assign bus.S2_ALUOp       = op_q;
    assign bus.S2_WriteSelect = ws_q;
    assign bus.S2_WriteEnable = valid_q & we_q;
endmodule
